// File: rtl/ppu_pkg.sv
// ============================================================================
// ppu_pkg: register indices, default raster geometry and PPUCTRL layout.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package ppu_pkg;

  localparam logic [2:0] PPUCTRL   = 3'd0;
  localparam logic [2:0] PPUSTATUS = 3'd2;

  localparam int DEF_DOTS_PER_LINE   = 341;
  localparam int DEF_LINES_PER_FRAME = 262;
  localparam int DEF_VBLANK_LINE     = 241;
  localparam int DEF_PRERENDER_LINE  = 261;

  typedef struct packed {
    logic       nmi_en;
    logic [6:0] other;
  } ppuctrl_t;

endpackage

`default_nettype wire

// File: rtl/ppu_raster_counter.sv
// ============================================================================
// ppu_raster_counter: dot/scanline counters with a one-clk frame_start pulse.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ppu_raster_counter
  import ppu_pkg::*;
#(
  parameter int DOTS_PER_LINE   = DEF_DOTS_PER_LINE,
  parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ce,
  output logic [8:0] o_dot,
  output logic [8:0] o_scanline,
  output logic       o_frame_start
);

  localparam logic [8:0] c_DOT_LAST  = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] c_LINE_LAST = 9'(LINES_PER_FRAME - 1);

  logic [8:0] r_dot;
  logic [8:0] r_line;
  logic       r_frame_start;
  logic       w_eol;
  logic       w_eof;

  assign w_eol = (r_dot == c_DOT_LAST);
  assign w_eof = w_eol && (r_line == c_LINE_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dot         <= 9'd0;
      r_line        <= 9'd0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= i_ce && w_eof;
      if (i_ce) begin
        if (w_eol) begin
          r_dot  <= 9'd0;
          r_line <= w_eof ? 9'd0 : r_line + 9'd1;
        end else begin
          r_dot <= r_dot + 9'd1;
        end
      end
    end
  end

  assign o_dot         = r_dot;
  assign o_scanline    = r_line;
  assign o_frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: rtl/ppu_vblank_nmi.sv
// ============================================================================
// ppu_vblank_nmi: vblank flag, NMI level and the $2000/$2002 CPU register port.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ppu_vblank_nmi
  import ppu_pkg::*;
#(
  parameter int DOTS_PER_LINE   = DEF_DOTS_PER_LINE,
  parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
  parameter int VBLANK_LINE     = DEF_VBLANK_LINE,
  parameter int PRERENDER_LINE  = DEF_PRERENDER_LINE
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ppu_ce,
  input  logic       i_reg_en,
  input  logic       i_reg_write,
  input  logic [2:0] i_reg_addr,
  input  logic [7:0] i_reg_din,
  output logic [7:0] o_reg_dout,
  output logic       o_nmi,
  output logic       o_vblank,
  output logic [7:0] o_ctrl,
  output logic [8:0] o_dot,
  output logic [8:0] o_scanline,
  output logic       o_frame_start
);

  localparam logic [8:0] c_VBL_LINE = 9'(VBLANK_LINE);
  localparam logic [8:0] c_PRE_LINE = 9'(PRERENDER_LINE);

  logic [8:0] w_dot;
  logic [8:0] w_line;
  logic       w_rd;
  logic       w_wr;
  logic       w_rd_status;
  logic       w_vbl_set;
  logic       w_vbl_clr;

  ppuctrl_t   r_ctrl;
  logic [7:0] r_latch;
  logic [7:0] r_dout;
  logic       r_vblank;
  logic       r_nmi;

  ppu_raster_counter #(
    .DOTS_PER_LINE   (DOTS_PER_LINE),
    .LINES_PER_FRAME (LINES_PER_FRAME)
  ) u_raster (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_ce          (i_ppu_ce),
    .o_dot         (w_dot),
    .o_scanline    (w_line),
    .o_frame_start (o_frame_start)
  );

  assign w_rd        = i_reg_en && !i_reg_write;
  assign w_wr        = i_reg_en && i_reg_write;
  assign w_rd_status = w_rd && (i_reg_addr == PPUSTATUS);
  // Events fire on the ce cycle that moves the raster from dot 0 to dot 1.
  assign w_vbl_set   = i_ppu_ce && (w_line == c_VBL_LINE) && (w_dot == 9'd0);
  assign w_vbl_clr   = i_ppu_ce && (w_line == c_PRE_LINE) && (w_dot == 9'd0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ctrl   <= '0;
      r_latch  <= 8'd0;
      r_dout   <= 8'd0;
      r_vblank <= 1'b0;
      r_nmi    <= 1'b0;
    end else begin
      // A status read coinciding with the set event wins: the frame loses its flag.
      if (w_vbl_set && !w_rd_status) begin
        r_vblank <= 1'b1;
      end else if (w_vbl_clr || w_rd_status) begin
        r_vblank <= 1'b0;
      end
      r_nmi <= r_vblank && r_ctrl.nmi_en;
      if (w_wr) begin
        r_latch <= i_reg_din;
        if (i_reg_addr == PPUCTRL) begin
          r_ctrl <= ppuctrl_t'(i_reg_din);
        end
      end
      if (w_rd) begin
        r_dout <= (i_reg_addr == PPUSTATUS) ? {r_vblank, 2'b00, r_latch[4:0]} : r_latch;
      end
    end
  end

  assign o_reg_dout = r_dout;
  assign o_nmi      = r_nmi;
  assign o_vblank   = r_vblank;
  assign o_ctrl     = r_ctrl;
  assign o_dot      = w_dot;
  assign o_scanline = w_line;

endmodule

`default_nettype wire

// File: tb/tb_ppu_vblank_nmi.sv
// ============================================================================
// tb_ppu_vblank_nmi: directed and random stimulus against a frame-position model.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ppu_vblank_nmi;

  localparam int D  = 24;
  localparam int L  = 14;
  localparam int VB = 10;
  localparam int PR = 13;
  localparam int FR = D * L;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0;
  logic       en = 1'b0;
  logic       wr = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] din = 8'd0;
  logic [7:0] dout;
  logic [7:0] ctrl;
  logic       nmi;
  logic       vblank;
  logic       fs;
  logic [8:0] dot;
  logic [8:0] line;

  int n_checks = 0;
  int n_errors = 0;

  // Model: position is simply the count of ce cycles since reset, modulo a frame.
  int         m_pos;
  bit         m_vb;
  bit         m_nmi;
  bit         m_fs;
  logic [7:0] m_ctrl;
  logic [7:0] m_latch;
  logic [7:0] m_dout;

  always #5 clk = ~clk;

  ppu_vblank_nmi #(
    .DOTS_PER_LINE   (D),
    .LINES_PER_FRAME (L),
    .VBLANK_LINE     (VB),
    .PRERENDER_LINE  (PR)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_ppu_ce      (ce),
    .i_reg_en      (en),
    .i_reg_write   (wr),
    .i_reg_addr    (addr),
    .i_reg_din     (din),
    .o_reg_dout    (dout),
    .o_nmi         (nmi),
    .o_vblank      (vblank),
    .o_ctrl        (ctrl),
    .o_dot         (dot),
    .o_scanline    (line),
    .o_frame_start (fs)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_vb = 0; m_nmi = 0; m_fs = 0;
    m_ctrl = 8'd0; m_latch = 8'd0; m_dout = 8'd0;
  endtask

  task automatic compare_all();
    check_eq("dot", 32'(dot), 32'(m_pos % D));
    check_eq("scanline", 32'(line), 32'(m_pos / D));
    check_eq("vblank", 32'(vblank), 32'(m_vb));
    check_eq("nmi", 32'(nmi), 32'(m_nmi));
    check_eq("ctrl", 32'(ctrl), 32'(m_ctrl));
    check_eq("reg_dout", 32'(dout), 32'(m_dout));
    check_eq("frame_start", 32'(fs), 32'(m_fs));
  endtask

  // Apply one clk of stimulus from a negedge, advance the model, compare at the next negedge.
  task automatic step(input bit c, input bit e, input bit w, input logic [2:0] a, input logic [7:0] d);
    bit         rd2;
    int         np;
    logic [7:0] st;
    ce = c; en = e; wr = w; addr = a; din = d;
    @(posedge clk);
    rd2   = e && !w && (a == 3'd2);
    np    = c ? (m_pos + 1) % FR : m_pos;
    st    = {m_vb, 2'b00, m_latch[4:0]};
    m_nmi = m_vb && m_ctrl[7];
    m_fs  = c && (np == 0);
    if (e && !w) m_dout = (a == 3'd2) ? st : m_latch;
    if (e && w) begin
      m_latch = d;
      if (a == 3'd0) m_ctrl = d;
    end
    if (c && np == VB * D + 1 && !rd2) m_vb = 1;
    else if ((c && np == PR * D + 1) || rd2) m_vb = 0;
    m_pos = np;
    @(negedge clk);
    compare_all();
    ce = 1'b0; en = 1'b0; wr = 1'b0;
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    while (m_pos != target && n < 2 * FR) begin
      step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
      n++;
    end
    check_eq("run_to_dot", 32'(dot), 32'(target % D));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    compare_all();
  endtask

  initial begin
    int n;
    logic [2:0] ra;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;

    // First vblank with NMI disabled
    run_to(VB * D + 1);
    check_eq("vbl_set", 32'(vblank), 32'd1);
    check_eq("vbl_no_nmi", 32'(nmi), 32'd0);

    // NMI enabled before vblank, then prerender clear
    do_reset();
    step(1'b0, 1'b1, 1'b1, 3'd0, 8'h80);
    run_to(VB * D + 1);
    check_eq("nmi_lag", 32'(nmi), 32'd0);
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
    check_eq("nmi_rise", 32'(nmi), 32'd1);
    run_to(PR * D + 1);
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
    check_eq("nmi_pre_clr", 32'(nmi), 32'd0);

    // Status read during vblank with latch=0x1F
    do_reset();
    step(1'b0, 1'b1, 1'b1, 3'd0, 8'h80);
    run_to(VB * D + 3);
    step(1'b0, 1'b1, 1'b1, 3'd5, 8'h1F);
    step(1'b0, 1'b1, 1'b0, 3'd2, 8'd0);
    check_eq("rd_status", 32'(dout), 32'h9F);
    check_eq("rd_clr_vbl", 32'(vblank), 32'd0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
    check_eq("rd_nmi_drop", 32'(nmi), 32'd0);
    step(1'b0, 1'b1, 1'b0, 3'd2, 8'd0);
    check_eq("rd_status2", 32'(dout), 32'h1F);

    // Toggle NMI enable while vblank is up
    do_reset();
    run_to(VB * D + 2);
    step(1'b0, 1'b1, 1'b1, 3'd0, 8'h80);
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
    check_eq("en_rise", 32'(nmi), 32'd1);
    step(1'b0, 1'b1, 1'b1, 3'd0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
    check_eq("en_fall", 32'(nmi), 32'd0);

    // Read in the exact set clk suppresses the frame; the next frame is normal
    do_reset();
    step(1'b0, 1'b1, 1'b1, 3'd0, 8'h80);
    run_to(VB * D);
    step(1'b1, 1'b1, 1'b0, 3'd2, 8'd0);
    check_eq("supp_bit7", 32'(dout[7]), 32'd0);
    check_eq("supp_vbl", 32'(vblank), 32'd0);
    run_to(PR * D + 1);
    run_to(VB * D + 1);
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
    check_eq("next_frame_nmi", 32'(nmi), 32'd1);

    // Asynchronous reset mid-vblank with nmi high
    rst = 1'b1;
    #1;
    check_eq("arst_nmi", 32'(nmi), 32'd0);
    check_eq("arst_vbl", 32'(vblank), 32'd0);
    check_eq("arst_dot", 32'(dot), 32'd0);
    check_eq("arst_line", 32'(line), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // frame_start period
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (n < 2 * FR) begin
        step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        n++;
        if (fs) break;
      end
      check_eq("fs_period", 32'(n), 32'(FR));
    end

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      case ($urandom % 4)
        0:       ra = 3'd0;
        1:       ra = 3'd2;
        default: ra = 3'($urandom % 8);
      endcase
      step(($urandom % 8) != 0, ($urandom % 6) == 0, ($urandom % 2) == 1, ra, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
